// File: rtl/final_project_soc_key_pio_in.sv
// Avalon-MM input PIO: synchronises and optionally debounces an external bus,
// captures edges sticky-style and raises a maskable level-sensitive irq.
module final_project_soc_key_pio_in #(
    parameter int WIDTH           = 12,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stableD;
    logic [WIDTH-1:0] r_edgeCapture;
    logic [WIDTH-1:0] r_irqMask;

    logic             w_wr;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_clear  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_unused = &{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES <= 1) begin : g_noFilter
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stable <= '0;
                end else begin
                    r_stable <= r_sync2;
                end
            end
        end else begin : g_filter
            logic [CW-1:0] r_cnt [WIDTH];

            // A bit must disagree with its stable value for N straight cycles to flip it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stable <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_sync2[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_stable[i] <= r_sync2[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign w_rise = r_stable & ~r_stableD;
    assign w_fall = ~r_stable & r_stableD;

    generate
        if (EDGE_TYPE == 0) begin : g_edgeRise
            assign w_edge = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_edgeFall
            assign w_edge = w_fall;
        end else begin : g_edgeAny
            assign w_edge = w_rise | w_fall;
        end
    endgenerate

    // A new edge outranks a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stableD     <= '0;
            r_edgeCapture <= '0;
            r_irqMask     <= '0;
        end else begin
            r_stableD     <= r_stable;
            r_edgeCapture <= w_edge | (r_edgeCapture & ~w_clear);
            if (w_wr && address == 2'd2) begin
                r_irqMask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_stable;
            2'd2:    readdata[WIDTH-1:0] = r_irqMask;
            2'd3:    readdata[WIDTH-1:0] = r_edgeCapture;
            default: readdata = '0;
        endcase
    end

    assign irq = |(r_edgeCapture & r_irqMask);

endmodule
